// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, the bubble down-counter width and
// the upper limit on load-use bubbles that the counter can represent.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      MD_WAIT   = 2'd2
   } hz_state_t;

   // Width of the load-use bubble down-counter.
   localparam int BUB_CNT_W = 4;

   // Largest bubble count the down-counter can hold.
   localparam int LOAD_USE_MAX = 15;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on each edge where inc=1, holds at all-ones.
// Latency: count reflects inc one edge later. No backpressure; inc is sampled every cycle.
// Ports: Clk (clock), Rst_n (sync active-low reset), inc (count enable), count (value).
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, mul/div busy stalls, EX branch flushes.
// Latency: Stall/BubbleEX/FlushIF/FlushID are combinational (same cycle); StallCount lags by one edge.
// Backpressure: Stall holds PC and IF/ID; a taken branch always overrides any stall.
// Ports: register specifiers and use flags from ID, load destination from EX, mul/div
// use/busy, branch resolution from EX; outputs are the pipeline controls plus StallCount.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W      = 5,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int MD_ENABLE       = 1,
   parameter int CNT_W           = 16
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [REG_ADDR_W-1:0] RS_ID,
   input  logic [REG_ADDR_W-1:0] RT_ID,
   input  logic                  UsesRS_ID,
   input  logic                  UsesRT_ID,
   input  logic [REG_ADDR_W-1:0] RD_EX,
   input  logic                  MemRead_EX,
   input  logic                  MdUse_ID,
   input  logic                  MdBusy,
   input  logic                  BranchTaken_EX,
   output logic                  Stall,
   output logic                  BubbleEX,
   output logic                  FlushIF,
   output logic                  FlushID,
   output logic [CNT_W-1:0]      StallCount
);

   // Out-of-range bubble counts are clamped into what the down-counter can hold.
   localparam int LU_EFF = (LOAD_USE_CYCLES < 1)            ? 1 :
                           (LOAD_USE_CYCLES > LOAD_USE_MAX) ? LOAD_USE_MAX :
                                                              LOAD_USE_CYCLES;
   localparam logic [BUB_CNT_W-1:0] BUB_RELOAD = BUB_CNT_W'(LU_EFF - 1);
   localparam logic [BUB_CNT_W-1:0] BUB_LAST   = BUB_CNT_W'(1);

   hz_state_t            state, state_nxt;
   logic [BUB_CNT_W-1:0] bub_cnt, bub_nxt;
   logic                 lu_hit, md_hit;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign lu_hit = MemRead_EX && (RD_EX != '0) &&
                   ((UsesRS_ID && (RD_EX == RS_ID)) || (UsesRT_ID && (RD_EX == RT_ID)));
   assign md_hit = (MD_ENABLE != 0) && MdUse_ID && MdBusy;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state   <= IDLE;
         bub_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bub_cnt <= bub_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bub_nxt   = bub_cnt;
      Stall     = 1'b0;
      BubbleEX  = 1'b0;
      FlushIF   = 1'b0;
      FlushID   = 1'b0;
      if (Rst_n) begin
         // A taken branch squashes the wrong-path instructions, so any pending
         // stall is moot: flush wins in every state and the FSM re-arms in IDLE.
         if (BranchTaken_EX) begin
            FlushIF   = 1'b1;
            FlushID   = 1'b1;
            state_nxt = IDLE;
            bub_nxt   = '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (lu_hit) begin
                     Stall    = 1'b1;
                     BubbleEX = 1'b1;
                     if (LU_EFF > 1) begin
                        state_nxt = LOAD_WAIT;
                        bub_nxt   = BUB_RELOAD;
                     end
                  end else if (md_hit) begin
                     Stall     = 1'b1;
                     BubbleEX  = 1'b1;
                     state_nxt = MD_WAIT;
                  end
               end
               LOAD_WAIT: begin
                  // The load has already left EX; remaining bubbles are unconditional.
                  Stall    = 1'b1;
                  BubbleEX = 1'b1;
                  bub_nxt  = bub_cnt - 1'b1;
                  if (bub_cnt == BUB_LAST) begin
                     state_nxt = IDLE;
                  end
               end
               MD_WAIT: begin
                  Stall    = MdBusy;
                  BubbleEX = MdBusy;
                  if (!MdBusy) begin
                     state_nxt = IDLE;
                  end
               end
               default: begin
                  state_nxt = IDLE;
                  bub_nxt   = '0;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .inc   (Stall),
      .count (StallCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: four parameterisations share one input set.
// Instance 0: defaults; 1: LOAD_USE_CYCLES=3; 2: MD_ENABLE=0; 3: CNT_W=3.
// Expected results are queued when stimulus is driven and checked at the falling edge.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] rs, rt, rd;
   logic       urs, urt, mr, mdu, mdb, br;

   logic        stall [4];
   logic        bub   [4];
   logic        fif   [4];
   logic        fid   [4];
   logic [15:0] cnt0, cnt1, cnt2;
   logic [2:0]  cnt3;

   hazard_ctrl dut0 (
      .Clk(clk), .Rst_n(rst_n), .RS_ID(rs), .RT_ID(rt), .UsesRS_ID(urs), .UsesRT_ID(urt),
      .RD_EX(rd), .MemRead_EX(mr), .MdUse_ID(mdu), .MdBusy(mdb), .BranchTaken_EX(br),
      .Stall(stall[0]), .BubbleEX(bub[0]), .FlushIF(fif[0]), .FlushID(fid[0]), .StallCount(cnt0));

   hazard_ctrl #(.LOAD_USE_CYCLES(3)) dut1 (
      .Clk(clk), .Rst_n(rst_n), .RS_ID(rs), .RT_ID(rt), .UsesRS_ID(urs), .UsesRT_ID(urt),
      .RD_EX(rd), .MemRead_EX(mr), .MdUse_ID(mdu), .MdBusy(mdb), .BranchTaken_EX(br),
      .Stall(stall[1]), .BubbleEX(bub[1]), .FlushIF(fif[1]), .FlushID(fid[1]), .StallCount(cnt1));

   hazard_ctrl #(.MD_ENABLE(0)) dut2 (
      .Clk(clk), .Rst_n(rst_n), .RS_ID(rs), .RT_ID(rt), .UsesRS_ID(urs), .UsesRT_ID(urt),
      .RD_EX(rd), .MemRead_EX(mr), .MdUse_ID(mdu), .MdBusy(mdb), .BranchTaken_EX(br),
      .Stall(stall[2]), .BubbleEX(bub[2]), .FlushIF(fif[2]), .FlushID(fid[2]), .StallCount(cnt2));

   hazard_ctrl #(.CNT_W(3)) dut3 (
      .Clk(clk), .Rst_n(rst_n), .RS_ID(rs), .RT_ID(rt), .UsesRS_ID(urs), .UsesRT_ID(urt),
      .RD_EX(rd), .MemRead_EX(mr), .MdUse_ID(mdu), .MdBusy(mdb), .BranchTaken_EX(br),
      .Stall(stall[3]), .BubbleEX(bub[3]), .FlushIF(fif[3]), .FlushID(fid[3]), .StallCount(cnt3));

   typedef struct {
      logic       rst_n;
      logic       mr;
      logic [4:0] rd;
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic       mdu;
      logic       mdb;
      logic       br;
   } in_t;

   typedef struct {
      in_t       in;
      logic [3:0] ctl;   // {Stall, BubbleEX, FlushIF, FlushID}
      int        cnt;
      hz_state_t st;
   } vec_t;

   typedef struct {
      int         inst;
      logic [3:0] ctl;
      int         cnt;
      hz_state_t  st;
      string      tag;
   } exp_t;

   localparam logic [3:0] C_NONE  = 4'b0000;
   localparam logic [3:0] C_STALL = 4'b1100;
   localparam logic [3:0] C_FLUSH = 4'b0011;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];

   function automatic in_t mk(input logic rst_n_v, input logic mr_v, input logic [4:0] rd_v,
                              input logic [4:0] rs_v, input logic urs_v, input logic [4:0] rt_v,
                              input logic urt_v, input logic mdu_v, input logic mdb_v,
                              input logic br_v);
      in_t r;
      r.rst_n = rst_n_v; r.mr = mr_v; r.rd = rd_v; r.rs = rs_v; r.urs = urs_v;
      r.rt = rt_v; r.urt = urt_v; r.mdu = mdu_v; r.mdb = mdb_v; r.br = br_v;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input in_t in);
      rst_n = in.rst_n; mr = in.mr; rd = in.rd; rs = in.rs; urs = in.urs;
      rt = in.rt; urt = in.urt; mdu = in.mdu; mdb = in.mdb; br = in.br;
   endtask

   // One cycle: drive inputs, queue the expectation, check it at the falling edge.
   task automatic cyc(input int inst, input in_t in, input logic [3:0] ctl, input int c,
                      input hz_state_t st, input string tag);
      exp_t        e;
      logic [3:0]  act_ctl;
      logic [31:0] act_cnt;
      hz_state_t   act_st;
      apply(in);
      e.inst = inst; e.ctl = ctl; e.cnt = c; e.st = st; e.tag = tag;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      act_ctl = {stall[e.inst], bub[e.inst], fif[e.inst], fid[e.inst]};
      case (e.inst)
         0:       begin act_cnt = 32'(cnt0); act_st = dut0.state; end
         1:       begin act_cnt = 32'(cnt1); act_st = dut1.state; end
         2:       begin act_cnt = 32'(cnt2); act_st = dut2.state; end
         default: begin act_cnt = 32'(cnt3); act_st = dut3.state; end
      endcase
      chk({e.tag, ".ctl"},   32'(act_ctl), 32'(e.ctl));
      chk({e.tag, ".cnt"},   act_cnt,      32'(e.cnt));
      chk({e.tag, ".state"}, 32'(act_st),  32'(e.st));
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst();
      apply(mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[20];
      in_t  z, lu8, lu5t, md, busy, brv;

      z    = mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      lu8  = mk(1, 1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0, 0);
      lu5t = mk(1, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0);
      md   = mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0);
      busy = mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      brv  = mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);

      tbl[0]  = '{mk(0, 1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0, 0), C_NONE,  0, IDLE};
      tbl[1]  = '{z,                                          C_NONE,  0, IDLE};
      tbl[2]  = '{lu8,                                        C_STALL, 0, IDLE};
      tbl[3]  = '{z,                                          C_NONE,  1, IDLE};
      tbl[4]  = '{mk(1, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0),  C_NONE,  1, IDLE};
      tbl[5]  = '{mk(1, 1, 5'd8, 5'd8, 0, 5'd0, 0, 0, 0, 0),  C_NONE,  1, IDLE};
      tbl[6]  = '{mk(1, 1, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 0),  C_STALL, 1, IDLE};
      tbl[7]  = '{mk(1, 0, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 0),  C_NONE,  2, IDLE};
      tbl[8]  = '{mk(1, 1, 5'd8, 5'd7, 1, 5'd8, 0, 0, 0, 0),  C_NONE,  2, IDLE};
      tbl[9]  = '{mk(1, 1, 5'd8, 5'd8, 1, 5'd0, 0, 0, 0, 1),  C_FLUSH, 2, IDLE};
      tbl[10] = '{z,                                          C_NONE,  2, IDLE};
      tbl[11] = '{md,                                         C_STALL, 2, IDLE};
      tbl[12] = '{busy,                                       C_STALL, 3, MD_WAIT};
      tbl[13] = '{z,                                          C_NONE,  4, MD_WAIT};
      tbl[14] = '{z,                                          C_NONE,  4, IDLE};
      tbl[15] = '{mk(1, 1, 5'd8, 5'd8, 1, 5'd0, 0, 1, 1, 0),  C_STALL, 4, IDLE};
      tbl[16] = '{z,                                          C_NONE,  5, IDLE};
      tbl[17] = '{md,                                         C_STALL, 5, IDLE};
      tbl[18] = '{mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1),  C_FLUSH, 6, MD_WAIT};
      tbl[19] = '{busy,                                       C_NONE,  6, IDLE};

      do_rst();
      for (int i = 0; i < 20; i++) begin
         cyc(0, tbl[i].in, tbl[i].ctl, tbl[i].cnt, tbl[i].st, $sformatf("vec%0d", i));
      end

      // Three-bubble load-use on an rt match.
      do_rst();
      cyc(1, lu5t, C_STALL, 0, IDLE,      "lu3.c0");
      cyc(1, z,    C_STALL, 1, LOAD_WAIT, "lu3.c1");
      cyc(1, z,    C_STALL, 2, LOAD_WAIT, "lu3.c2");
      cyc(1, z,    C_NONE,  3, IDLE,      "lu3.c3");

      // Branch during LOAD_WAIT cuts the bubble train short.
      do_rst();
      cyc(1, lu5t, C_STALL, 0, IDLE,      "lubr.c0");
      cyc(1, brv,  C_FLUSH, 1, LOAD_WAIT, "lubr.c1");
      cyc(1, z,    C_NONE,  1, IDLE,      "lubr.c2");
      cyc(1, z,    C_NONE,  1, IDLE,      "lubr.c3");

      // Mul/div busy for four cycles.
      do_rst();
      for (int i = 0; i < 4; i++) begin
         cyc(0, md, C_STALL, i, (i == 0) ? IDLE : MD_WAIT, $sformatf("md.c%0d", i));
      end
      cyc(0, mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0), C_NONE, 4, MD_WAIT, "md.drop");
      cyc(0, z, C_NONE, 4, IDLE, "md.after");

      // Mul/div logic compiled out: never stalls.
      do_rst();
      for (int i = 0; i < 4; i++) begin
         cyc(2, md, C_NONE, 0, IDLE, $sformatf("mdoff.c%0d", i));
      end

      // Reset asserted while in MD_WAIT.
      do_rst();
      cyc(0, md, C_STALL, 0, IDLE,    "rstmid.c0");
      cyc(0, md, C_STALL, 1, MD_WAIT, "rstmid.c1");
      cyc(0, mk(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0), C_NONE, 2, MD_WAIT, "rstmid.rst");
      cyc(0, busy, C_NONE, 0, IDLE, "rstmid.rel0");
      cyc(0, busy, C_NONE, 0, IDLE, "rstmid.rel1");

      // Three-bit counter saturates at 7.
      do_rst();
      for (int i = 0; i < 10; i++) begin
         cyc(3, md, C_STALL, (i > 7) ? 7 : i, (i == 0) ? IDLE : MD_WAIT, $sformatf("sat.c%0d", i));
      end
      cyc(3, mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0), C_NONE, 7, MD_WAIT, "sat.drop");
      cyc(3, z, C_NONE, 7, IDLE, "sat.hold");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage datapath. It generates stall, bubble and flush controls between IF/ID, ID/EX and the PC. It covers:
- load-use hazards with a configurable number of bubbles;
- stalls on a busy multi-cycle multiply/divide unit;
- taken-branch flushes resolved in EX.

A saturating counter tracks stall cycles for performance analysis.

## Interface
Parameters:
- REG_ADDR_W, 5, register specifier width
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (legal range 1..15)
- MD_ENABLE, 1, 1 = multiply/divide stall logic present; 0 = MdUse_ID and MdBusy ignored
- CNT_W, 16, width of StallCount

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst_n  in  1  synchronous, active-low reset
- RS_ID  in  REG_ADDR_W  rs of instruction in ID
- RT_ID  in  REG_ADDR_W  rt of instruction in ID
- UsesRS_ID  in  1  ID instruction reads rs
- UsesRT_ID  in  1  ID instruction reads rt
- RD_EX  in  REG_ADDR_W  destination register of instruction in EX
- MemRead_EX  in  1  EX instruction is a load
- MdUse_ID  in  1  ID instruction reads HI/LO or issues a mul/div
- MdBusy  in  1  mul/div unit still computing
- BranchTaken_EX  in  1  branch/jump in EX resolved taken
- Stall  out  1  hold PC and IF/ID
- BubbleEX  out  1  load NOP into ID/EX
- FlushIF  out  1  squash the instruction being fetched
- FlushID  out  1  squash IF/ID contents
- StallCount  out  CNT_W  saturating count of cycles with Stall=1

## Operation
- The state machine has three states: IDLE, LOAD_WAIT and MD_WAIT. A down-counter `bub_cnt` (4 bits) supports LOAD_WAIT.
- lu_hit = MemRead_EX & (RD_EX != 0) & ((UsesRS_ID & RD_EX==RS_ID) | (UsesRT_ID & RD_EX==RT_ID)).
- md_hit = MD_ENABLE & MdUse_ID & MdBusy.
- **IDLE:**
  - BranchTaken_EX=1: FlushIF=FlushID=1, Stall=0, stay in IDLE. Flush has priority over every hit.
  - Otherwise, lu_hit=1: Stall=BubbleEX=1. If LOAD_USE_CYCLES>1, go to LOAD_WAIT with bub_cnt=LOAD_USE_CYCLES-1; otherwise stay in IDLE.
  - Otherwise, md_hit=1: Stall=BubbleEX=1 and go to MD_WAIT. lu_hit takes priority when both hits are present.
- **LOAD_WAIT:**
  - Stall=BubbleEX=1 unconditionally. The hit is not re-evaluated, because the load has left EX.
  - bub_cnt decrements each cycle. When bub_cnt==1, return to IDLE on the next edge.
- **MD_WAIT:**
  - Stall=BubbleEX=MdBusy.
  - When MdBusy=0, Stall=0 in that same cycle and the state returns to IDLE.
- **BranchTaken_EX in LOAD_WAIT or MD_WAIT:**
  - Flush wins: FlushIF=FlushID=1 and Stall=BubbleEX=0.
  - Next state is IDLE and bub_cnt is cleared.
- **StallCount:** +1 on every edge where Stall=1. It holds at 2^CNT_W-1 and never wraps.

## Timing
- Stall, BubbleEX, FlushIF and FlushID are combinational from the current state and inputs, with zero latency. The ID-stage hazard is visible in the same cycle.
- A load-use hazard produces exactly LOAD_USE_CYCLES consecutive Stall cycles, starting in the cycle of detection.
- An MD stall lasts while MdBusy=1 and ends in the first cycle MdBusy=0.
- **While Rst_n=0:**
  - Stall, BubbleEX, FlushIF and FlushID are forced to 0.
  - On the edge, state←IDLE, bub_cnt←0 and StallCount←0.
- **Reset asserted mid-stall:** abandons LOAD_WAIT or MD_WAIT at the next edge. Stall is 0 in the reset cycle itself.
- Flush and Stall are never 1 in the same cycle.

## Structure
- hazard_pkg holds:
  - the state enum (IDLE, LOAD_WAIT, MD_WAIT);
  - the BUB_CNT_W=4 constant;
  - the LOAD_USE_CYCLES legality limit (15).
- One sub-module, sat_counter, parametrised by width, with inputs Clk, Rst_n and inc, and output count. It is instantiated for StallCount.
- Comparators and the next-state logic live in hazard_ctrl.

## Test plan
- **Load-use, default parameters.** Stimulus: MemRead_EX=1, RD_EX=8, RS_ID=8, UsesRS_ID=1 for one cycle. Required: Stall=BubbleEX=1 for exactly 1 cycle, then StallCount=1. Repeat with RD_EX=0 or UsesRS_ID=0: no stall.
- **Multi-bubble load-use.** LOAD_USE_CYCLES=3, RT match on register 5, lasting one cycle. Required: Stall=1 for exactly 3 cycles, LOAD_WAIT visited for 2 of them, StallCount=3.
- **MD stall.** MdUse_ID=1 with MdBusy high for 4 cycles. Required: Stall=1 for 4 cycles and 0 in the cycle MdBusy falls. With MD_ENABLE=0: never stalls.
- **Flush priority.** BranchTaken_EX=1 together with lu_hit. Required: FlushIF=FlushID=1, Stall=0, state stays IDLE. Also assert BranchTaken_EX in the 2nd cycle of a 3-cycle LOAD_WAIT: Stall drops to 0 and state returns to IDLE.
- **Reset mid-stall.** Drive Rst_n=0 during MD_WAIT with MdBusy=1. Required: all outputs 0 during reset, StallCount=0 afterwards, no stall after release while MdUse_ID=0.
- **Saturation.** CNT_W=3, hold md_hit for 10 cycles. Required: StallCount reaches 7 and holds.
